bsg_serial_scatter: RTL and testbench



---
 rtl/bsg_serial_scatter.sv | 77 +++++++
 tb/tb_bsg_serial_scatter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_serial_scatter.sv
// bsg_serial_scatter: restores a compacted serial word stream into lane positions
// selected by a mask, lowest set lane first, emitting one sparse vector per mask.
module bsg_serial_scatter #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     mask_v_i,
    input  logic [els_p-1:0]         mask_i,
    output logic                     mask_ready_o,
    input  logic                     data_v_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     data_ready_o,
    output logic                     v_o,
    output logic [els_p*width_p-1:0] data_o,
    output logic [els_p-1:0]         mask_o,
    input  logic                     ready_i
);
    // state | meaning
    // IDLE  | waiting for a mask
    // FILL  | depositing packed words into lanes still pending in pend_r
    // DONE  | vector presented on data_o/mask_o until ready_i
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

    state_e                        state_r;
    logic [els_p-1:0]              pend_r;
    logic [els_p-1:0]              mask_r;
    logic [els_p-1:0][width_p-1:0] lane_r;
    logic [els_p-1:0]              pick;
    logic [els_p-1:0]              pend_next;
    logic                          mask_hs;
    logic                          data_hs;

    // Isolate the lowest set pending bit: target lane for the next word.
    assign pick      = pend_r & (-pend_r);
    assign pend_next = pend_r & ~pick;

    assign mask_ready_o = (state_r == IDLE) || ((state_r == DONE) && ready_i);
    assign data_ready_o = (state_r == FILL);
    assign v_o          = (state_r == DONE);
    assign data_o       = lane_r;
    assign mask_o       = mask_r;

    assign mask_hs = mask_v_i && mask_ready_o;
    assign data_hs = data_v_i && data_ready_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            pend_r  <= '0;
            mask_r  <= '0;
            lane_r  <= '0;
        end else begin
            if (mask_hs) begin
                // Also covers the back-to-back reload on the retire cycle of DONE.
                mask_r  <= mask_i;
                pend_r  <= mask_i;
                lane_r  <= '0;
                state_r <= (mask_i != '0) ? FILL : DONE;
            end else if ((state_r == DONE) && ready_i) begin
                state_r <= IDLE;
            end else if (data_hs) begin
                for (int i = 0; i < els_p; i++) begin
                    if (pick[i]) begin
                        lane_r[i] <= data_i;
                    end
                end
                pend_r <= pend_next;
                if (pend_next == '0) begin
                    state_r <= DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_serial_scatter.sv
// Scoreboard bench for bsg_serial_scatter: directed timing/placement vectors plus
// a long randomized valid/ready run against a lowest-lane-first scatter model.
`timescale 1ns/1ps
module tb_bsg_serial_scatter;
    logic        clk;
    logic        reset_n_i;
    logic        mask_v_i;
    logic [3:0]  mask_i;
    logic        mask_ready_o;
    logic        data_v_i;
    logic [7:0]  data_i;
    logic        data_ready_o;
    logic        v_o;
    logic [31:0] data_o;
    logic [3:0]  mask_o;
    logic        ready_i;

    int n_vec  = 0;
    int n_miss = 0;

    logic [35:0] exp_q[$];
    logic [3:0]  mq[$];
    logic [7:0]  wq[$];
    logic        drv_en = 0;
    int          p_mv   = 100;
    int          p_dv   = 100;
    int          p_rdy  = 100;

    bsg_serial_scatter #(.width_p(8), .els_p(4)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n_i),
        .mask_v_i     (mask_v_i),
        .mask_i       (mask_i),
        .mask_ready_o (mask_ready_o),
        .data_v_i     (data_v_i),
        .data_i       (data_i),
        .data_ready_o (data_ready_o),
        .v_o          (v_o),
        .data_o       (data_o),
        .mask_o       (mask_o),
        .ready_i      (ready_i)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every retired vector is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (v_o && ready_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL retire_unexpected: got mask %b data %h, expected no vector", mask_o, data_o);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({mask_ready_o, data_ready_o, mask_o, data_o} !== {2'b10, e}) begin
                    n_miss++;
                    $display("FAIL retire: got mrdy %b drdy %b mask %b data %h, expected mrdy 1 drdy 0 mask %b data %h",
                             mask_ready_o, data_ready_o, mask_o, data_o, e[35:32], e[31:0]);
                end
            end
        end
    end

    // Queue-driven stimulus for back-to-back and random phases.
    always begin
        logic mhs, dhs;
        @(negedge clk);
        mhs = mask_v_i && mask_ready_o;
        dhs = data_v_i && data_ready_o;
        @(posedge clk);
        #1;
        if (drv_en) begin
            if (mhs && mq.size() > 0) void'(mq.pop_front());
            if (dhs && wq.size() > 0) void'(wq.pop_front());
            mask_v_i = (mq.size() > 0) && ($urandom_range(99) < p_mv);
            mask_i   = (mq.size() > 0) ? mq[0] : 4'h0;
            data_v_i = (wq.size() > 0) && ($urandom_range(99) < p_dv);
            data_i   = (wq.size() > 0) ? wq[0] : 8'($urandom);
            ready_i  = ($urandom_range(99) < p_rdy);
        end
    end

    // One manually driven vector starting from IDLE; checks latency, hold and stall behaviour.
    task automatic directed(input string name, input logic [3:0] m, input logic [31:0] words,
                            input int gap, input int hold, input logic [31:0] exp_d);
        int          n;
        logic        ok;
        logic [31:0] d0;
        n = $countones(m);
        exp_q.push_back({m, exp_d});
        mask_i   = m;
        mask_v_i = 1;
        ready_i  = 0;
        cyc();
        mask_v_i = 0;
        mask_i   = 4'h0;
        ok = 1;
        for (int k = 0; k < n; k++) begin
            if (k == n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    data_v_i = 0;
                    data_i   = 8'hEE;
                    @(negedge clk);
                    if (v_o || !data_ready_o) ok = 0;
                    cyc();
                end
            end
            data_v_i = 1;
            data_i   = words[k*8 +: 8];
            @(negedge clk);
            if (v_o || !data_ready_o) ok = 0;
            cyc();
        end
        if (n > 0) data_v_i = 0;
        @(negedge clk);
        chk({name, "_no_early_v"}, ok, 1);
        chk({name, "_latency_v"}, v_o, 1);
        d0 = data_o;
        ok = 1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!v_o || data_o !== d0 || data_ready_o || mask_ready_o) ok = 0;
            cyc();
        end
        if (hold > 0) chk({name, "_hold"}, ok, 1);
        ready_i = 1;
        cyc();
        ready_i = 0;
    endtask

    initial begin
        reset_n_i = 0;
        mask_v_i  = 0;
        mask_i    = 0;
        data_v_i  = 0;
        data_i    = 0;
        ready_i   = 0;
        #12;
        chk("reset_outs", {v_o, mask_ready_o, data_ready_o, mask_o, data_o}, {3'b010, 4'h0, 32'h0});
        cyc();
        reset_n_i = 1;
        cyc();

        // Reset in the middle of filling mask 1010 after one word.
        mask_i   = 4'b1010;
        mask_v_i = 1;
        cyc();
        mask_v_i = 0;
        data_v_i = 1;
        data_i   = 8'h11;
        cyc();
        data_v_i = 0;
        chk("midfill_drdy", data_ready_o, 1);
        #2;
        reset_n_i = 0;
        #1;
        chk("midfill_reset_v", v_o, 0);
        chk("midfill_reset_data", data_o, 32'h0);
        chk("midfill_reset_rdy", {mask_ready_o, data_ready_o, mask_o}, {2'b10, 4'h0});
        cyc();
        reset_n_i = 1;
        cyc();

        directed("basic", 4'b1011, 32'h00C3_B2A1, 0, 0, 32'hC300_B2A1);
        data_v_i = 1;
        data_i   = 8'h77;
        directed("zero", 4'b0000, 32'h0, 0, 1, 32'h0);
        data_v_i = 0;
        directed("full", 4'b1111, 32'h0403_0201, 0, 0, 32'h0403_0201);
        directed("stall", 4'b0100, 32'h0000_005A, 3, 4, 32'h005A_0000);

        // Back-to-back: retire cycle of each vector accepts the next mask.
        @(negedge clk);
        mq.push_back(4'b0001); mq.push_back(4'b0000); mq.push_back(4'b1000);
        wq.push_back(8'h3C);   wq.push_back(8'h96);
        exp_q.push_back({4'b0001, 32'h0000_003C});
        exp_q.push_back({4'b0000, 32'h0000_0000});
        exp_q.push_back({4'b1000, 32'h9600_0000});
        p_mv = 100; p_dv = 100; p_rdy = 100;
        drv_en = 1;
        repeat (6) @(posedge clk);
        #2;
        chk("b2b_cycle5", {exp_q.size() == 1, v_o}, 2'b11);
        @(posedge clk);
        #2;
        chk("b2b_cycle6", {exp_q.size() == 0, v_o}, 2'b10);
        drv_en = 0;
        mask_v_i = 0; data_v_i = 0; ready_i = 0;
        cyc();

        // Random masks, words and valid/ready gaps against a scatter model.
        @(negedge clk);
        for (int v = 0; v < 10000; v++) begin
            logic [3:0]  m;
            logic [31:0] d;
            logic [7:0]  w;
            m = 4'($urandom_range(15));
            d = '0;
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    w = 8'($urandom);
                    d[i*8 +: 8] = w;
                    wq.push_back(w);
                end
            end
            mq.push_back(m);
            exp_q.push_back({m, d});
        end
        p_mv = 85; p_dv = 80; p_rdy = 80;
        drv_en = 1;
        begin
            logic drained;
            drained = 0;
            for (int c = 0; c < 80000 && !drained; c++) begin
                @(posedge clk);
                #2;
                if (exp_q.size() == 0) drained = 1;
            end
            chk("random_drain", drained, 1);
        end
        drv_en = 0;
        mask_v_i = 0; data_v_i = 0; ready_i = 0;
        chk("random_words_used", wq.size(), 0);
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
